// File: rtl/discharge_pkg.sv
// Shared types and widths for the buck discharge stage.
package discharge_pkg;

  localparam int I_W   = 16;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    PH_OFF   = 3'd0,
    PH_LO    = 3'd1,
    PH_DT_HI = 3'd2,
    PH_HI    = 3'd3,
    PH_DT_LO = 3'd4
  } phase_state_t;

endpackage

// File: rtl/buck_phase_fsm.sv
// One buck leg: hysteresis thresholds, dwell counter, phase FSM and registered gate decode.
module buck_phase_fsm
  import discharge_pkg::*;
#(
  parameter int unsigned DEAD_TIME = 8,
  parameter int unsigned MIN_ON    = 20,
  parameter int unsigned MIN_OFF   = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stop,
  input  logic           allow_on,
  input  logic [I_W-1:0] target,
  input  logic [I_W-1:0] i_meas,
  input  logic [I_W-1:0] hyst,
  input  logic [I_W-1:0] i_limit,
  output logic           gate_hi,
  output logic           gate_lo,
  output logic           ocp,
  output logic           want_on,
  output logic [2:0]     state_dbg
);

  localparam logic [CNT_W-1:0] DT_LAST   = CNT_W'(DEAD_TIME - 1);
  localparam logic [CNT_W-1:0] MIN_ON_C  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] MIN_OFF_C = CNT_W'(MIN_OFF);

  phase_state_t     state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [I_W-1:0]   half_h, upper, lower;
  logic [I_W:0]     upper_sum, lower_diff;

  // Thresholds in 17 bits so the carry/borrow selects saturation.
  assign half_h     = hyst >> 1;
  assign upper_sum  = {1'b0, target} + {1'b0, half_h};
  assign lower_diff = {1'b0, target} - {1'b0, half_h};
  assign upper      = upper_sum[I_W]  ? '1 : upper_sum[I_W-1:0];
  assign lower      = lower_diff[I_W] ? '0 : lower_diff[I_W-1:0];

  assign ocp       = (i_meas >= i_limit);
  assign want_on   = (state == PH_LO) && (cnt >= MIN_OFF_C) &&
                     (target != '0) && (i_meas < lower);
  assign state_dbg = state;

  always_comb begin
    state_n = state;
    if (stop) begin
      state_n = PH_OFF;
    end else begin
      case (state)
        PH_OFF:   state_n = PH_LO;
        PH_LO:    if (want_on && allow_on) state_n = PH_DT_HI;
        PH_DT_HI: if (cnt >= DT_LAST) state_n = PH_HI;
        PH_HI:    if ((cnt >= MIN_ON_C) && (i_meas >= upper)) state_n = PH_DT_LO;
        PH_DT_LO: if (cnt >= DT_LAST) state_n = PH_LO;
        default:  state_n = PH_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PH_OFF;
      cnt     <= '0;
      gate_hi <= 1'b0;
      gate_lo <= 1'b0;
    end else begin
      state   <= state_n;
      gate_hi <= (state_n == PH_HI);
      gate_lo <= (state_n == PH_LO);
      // Coming out of OFF the minimum off-time counts as already served.
      if (state_n != state)
        cnt <= ((state == PH_OFF) && (state_n == PH_LO)) ? MIN_OFF_C : '0;
      else if (cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/buck_hyst_current_ctrl.sv
// Two-phase interleaved hysteretic current regulator: target split, fault latch, turn-on arbitration.
module buck_hyst_current_ctrl
  import discharge_pkg::*;
#(
  parameter int unsigned DEAD_TIME = 8,
  parameter int unsigned MIN_ON    = 20,
  parameter int unsigned MIN_OFF   = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] i_set,
  input  logic [15:0] i_meas_a,
  input  logic [15:0] i_meas_b,
  input  logic [15:0] hyst,
  input  logic [15:0] i_limit,
  output logic        gate_hi_a,
  output logic        gate_lo_a,
  output logic        gate_hi_b,
  output logic        gate_lo_b,
  output logic        fault,
  output logic        busy
);

  localparam logic PRIO_A = 1'b1;

  logic [I_W-1:0] target;
  logic           ocp_a, ocp_b, want_on_a, want_on_b;
  logic           allow_on_a, allow_on_b, stop;
  logic [2:0]     st_a, st_b;

  assign target = i_set >> 1;
  // An overcurrent seen this cycle shuts both legs at the same edge that latches fault.
  assign stop   = !enable || fault || ocp_a || ocp_b;

  // Fixed-priority interleave: the lower-priority leg holds in LO while the other is turning on.
  assign allow_on_a = PRIO_A || ((st_b != PH_DT_HI) && !want_on_b);
  assign allow_on_b = !PRIO_A || ((st_a != PH_DT_HI) && !want_on_a);

  assign busy = (st_a != PH_OFF) || (st_b != PH_OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fault <= 1'b0;
    else if (!enable)
      fault <= 1'b0;
    else if (ocp_a || ocp_b)
      fault <= 1'b1;
  end

  buck_phase_fsm #(
    .DEAD_TIME (DEAD_TIME),
    .MIN_ON    (MIN_ON),
    .MIN_OFF   (MIN_OFF)
  ) u_phase_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .stop      (stop),
    .allow_on  (allow_on_a),
    .target    (target),
    .i_meas    (i_meas_a),
    .hyst      (hyst),
    .i_limit   (i_limit),
    .gate_hi   (gate_hi_a),
    .gate_lo   (gate_lo_a),
    .ocp       (ocp_a),
    .want_on   (want_on_a),
    .state_dbg (st_a)
  );

  buck_phase_fsm #(
    .DEAD_TIME (DEAD_TIME),
    .MIN_ON    (MIN_ON),
    .MIN_OFF   (MIN_OFF)
  ) u_phase_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .stop      (stop),
    .allow_on  (allow_on_b),
    .target    (target),
    .i_meas    (i_meas_b),
    .hyst      (hyst),
    .i_limit   (i_limit),
    .gate_hi   (gate_hi_b),
    .gate_lo   (gate_lo_b),
    .ocp       (ocp_b),
    .want_on   (want_on_b),
    .state_dbg (st_b)
  );

endmodule

// File: tb/tb_buck_hyst_current_ctrl.sv
// Directed bench for buck_hyst_current_ctrl with DEAD_TIME=4, MIN_ON=8, MIN_OFF=8.
module tb_buck_hyst_current_ctrl;

  logic        clk, rst_n, enable;
  logic [15:0] i_set, i_meas_a, i_meas_b, hyst, i_limit;
  logic        gate_hi_a, gate_lo_a, gate_hi_b, gate_lo_b, fault, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  buck_hyst_current_ctrl #(
    .DEAD_TIME (4),
    .MIN_ON    (8),
    .MIN_OFF   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .i_set     (i_set),
    .i_meas_a  (i_meas_a),
    .i_meas_b  (i_meas_b),
    .hyst      (hyst),
    .i_limit   (i_limit),
    .gate_hi_a (gate_hi_a),
    .gate_lo_a (gate_lo_a),
    .gate_hi_b (gate_hi_b),
    .gate_lo_b (gate_lo_b),
    .fault     (fault),
    .busy      (busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output vector order: {hi_a, lo_a, hi_b, lo_b, fault, busy}
  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] got;
    got = {gate_hi_a, gate_lo_a, gate_hi_b, gate_lo_b, fault, busy};
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (hi_a lo_a hi_b lo_b fault busy)", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    n_cmp++;
    assert (!(gate_hi_a && gate_lo_a) && !(gate_hi_b && gate_lo_b)) else begin
      n_fail++;
      $error("FAIL gate_overlap: observed a=%b%b b=%b%b expected no leg with both gates on",
             gate_hi_a, gate_lo_a, gate_hi_b, gate_lo_b);
    end
  end

  initial begin
    rst_n    = 1'b1;
    enable   = 1'b0;
    i_set    = 16'd0;
    i_meas_a = 16'd0;
    i_meas_b = 16'd0;
    hyst     = 16'd20;
    i_limit  = 16'hFFFF;
    #1 rst_n = 1'b0;
    #1 check("reset_state", 6'b000000);
    step(2);
    check("reset_held", 6'b000000);
    rst_n = 1'b1;
    step(1);
    check("idle_after_reset", 6'b000000);

    // Regulation: target 100, band 90..110; B parked at 100 so it stays in LO.
    enable = 1'b1; i_set = 16'd200; i_meas_a = 16'd0; i_meas_b = 16'd100;
    step(1); check("reg_off_to_lo", 6'b010101);
    step(1); check("reg_dt_hi_entry", 6'b000101);
    step(3); check("reg_dt_hi_hold", 6'b000101);
    step(1); check("reg_hi_entry", 6'b100101);
    for (int j = 0; j < 8; j++) begin
      i_meas_a = 16'(30 + 10 * j);
      step(1); check("reg_hi_ramp", 6'b100101);
    end
    i_meas_a = 16'd110;
    step(1); check("reg_turn_off", 6'b000101);
    i_meas_a = 16'd120;
    step(3); check("reg_dt_lo_hold", 6'b000101);
    step(1); check("reg_lo_entry", 6'b010101);
    i_meas_a = 16'd90;
    step(9); check("reg_lower_boundary", 6'b010101);
    i_meas_a = 16'd89;
    step(1); check("reg_below_lower", 6'b000101);
    step(3); check("reg_dt_hi_hold2", 6'b000101);
    step(1); check("reg_hi_again", 6'b100101);

    // Minimum on-time, then minimum off-time.
    step(2);
    i_meas_a = 16'd150;
    step(6); check("min_on_hold", 6'b100101);
    step(1); check("min_on_release", 6'b000101);
    i_meas_a = 16'd50;
    step(4); check("min_off_lo_entry", 6'b010101);
    step(8); check("min_off_hold", 6'b010101);
    step(1); check("min_off_release", 6'b000101);

    // Interleave: both legs qualify together.
    enable = 1'b0;
    step(1); check("disable_all_off", 6'b000000);
    i_meas_a = 16'd50; i_meas_b = 16'd50; enable = 1'b1;
    step(1); check("il_both_lo", 6'b010101);
    step(1); check("il_a_first", 6'b000101);
    step(3); check("il_b_waits", 6'b000101);
    step(1); check("il_a_hi_b_waits", 6'b100101);
    step(1); check("il_b_dt_hi", 6'b100001);
    step(3); check("il_b_dt_hold", 6'b100001);
    step(1); check("il_b_hi", 6'b101001);

    // Overcurrent on B while in HI.
    i_limit = 16'd300; i_meas_b = 16'd299;
    step(1); check("ocp_below_limit", 6'b101001);
    i_meas_b = 16'd300;
    step(1); check("ocp_trip", 6'b000010);
    i_meas_b = 16'd0;
    step(3); check("fault_holds", 6'b000010);
    enable = 1'b0;
    step(1); check("fault_clear", 6'b000000);
    i_meas_b = 16'd300;
    step(1); check("clear_wins", 6'b000000);
    enable = 1'b1;
    step(1); check("ocp_blocks_start", 6'b000010);
    i_meas_b = 16'd0; enable = 1'b0;
    step(1); check("fault_clear2", 6'b000000);

    // Zero setpoint: both low-side gates on, high sides stay off.
    i_set = 16'd0; i_meas_a = 16'd0; i_meas_b = 16'd0; enable = 1'b1;
    step(1); check("zero_lo", 6'b010101);
    for (int k = 0; k < 1000; k++) begin
      step(1); check("zero_hold", 6'b010101);
    end

    // Asynchronous reset while A is in HI.
    i_set = 16'd200; i_meas_a = 16'd50; i_meas_b = 16'd100;
    step(1); check("rst_pre_dt", 6'b000101);
    step(4); check("rst_pre_hi", 6'b100101);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 6'b000000);
    step(1); check("rst_hold", 6'b000000);
    #2 rst_n = 1'b1;
    #1 check("rst_release_off", 6'b000000);
    step(1); check("rst_restart_lo", 6'b010101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/buck_hyst_current_ctrl.md
# buck_hyst_current_ctrl

Two-phase interleaved hysteretic current regulator for the buck discharge stage. It sits downstream of the current-setpoint generator: each cycle it takes the commanded discharge current `i_set` and the two measured phase currents, and drives the high/low gate pairs of both buck legs. It inserts dead time, enforces minimum on/off times and latches an overcurrent fault.

## Interface
- `DEAD_TIME`, default 8: both gates of a leg are low for this many clk cycles on every high/low changeover.
- `MIN_ON`, default 20: minimum cycles spent in HI before a current-triggered turn-off.
- `MIN_OFF`, default 20: minimum cycles spent in LO before a current-triggered turn-on.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: regulation enable. Low forces all gates off.
- `i_set` in 16: total commanded current, unsigned. Each phase target is `i_set >> 1`.
- `i_meas_a` in 16: phase A measured current, unsigned, same scale as `i_set`.
- `i_meas_b` in 16: phase B measured current, unsigned.
- `hyst` in 16: full hysteresis band width, unsigned.
- `i_limit` in 16: overcurrent threshold per phase, unsigned.
- `gate_hi_a`, `gate_lo_a` out 1 each: phase A high/low switch gates.
- `gate_hi_b`, `gate_lo_b` out 1 each: phase B high/low switch gates.
- `fault` out 1: latched overcurrent flag.
- `busy` out 1: high while either phase FSM is not in OFF.

## Operation
- Per-phase thresholds are computed in 17 bits.
  - `upper = target + (hyst>>1)`, saturated at 0xFFFF.
  - `lower = target - (hyst>>1)`, saturated at 0.
- Each phase has its own FSM with states OFF, DT_HI, HI, DT_LO, LO, and its own cycle counter.
  - OFF: all gates low. Go to LO when `enable`=1 and `fault`=0. The counter is preset so that MIN_OFF counts as already satisfied.
  - LO: `gate_lo`=1. Go to DT_HI when the counter ≥ MIN_OFF, `target`≠0 and `i_meas < lower`.
  - DT_HI: both gates low for DEAD_TIME cycles, then go to HI.
  - HI: `gate_hi`=1. Go to DT_LO when the counter ≥ MIN_ON and `i_meas ≥ upper`.
  - DT_LO: both gates low for DEAD_TIME cycles, then go to LO.
  - The counter clears on every state entry and saturates at its maximum.
- Interleave: phase B may leave LO only while phase A is not in DT_HI. If both phases qualify on the same cycle, A wins and B waits at least one cycle. This prevents simultaneous turn-on edges.
- `i_set`=0 with `enable`=1: both phases sit in LO, so low-side gates are on and current decays.
- Fault: either `i_meas ≥ i_limit` on any cycle sets `fault`.
  - Both FSMs go to OFF at the next edge, from any state.
  - `fault` clears only when `enable` is sampled low.
  - If `enable` is low and overcurrent is present on the same cycle, clear wins.
- `enable` low from any state: both FSMs go to OFF at the next edge. No dead time is needed because both gates go low.
- Invariant: `gate_hi_x` and `gate_lo_x` are never both 1, in any state, reset or fault.

## Timing
- Reset values: all gates 0, `fault` 0, `busy` 0, both FSMs in OFF, counters 0.
- Gates are registered and decoded from the next state.
  - An input condition present before edge k changes the gates at edge k, i.e. 1-cycle latency.
- Turn-off dead-band: the gate goes low at edge k and the opposite gate goes high at edge k+DEAD_TIME.
- A fault detected before edge k puts all gates low after edge k.
- Inputs are sampled every cycle. No pipeline stall and no handshake.

## Structure
- Shared package `discharge_pkg` holds:
  - phase state encodings, e.g. `PH_OFF`, `PH_LO`, `PH_DT_HI`, `PH_HI`, `PH_DT_LO`;
  - the 16-bit current width constant.
- Sub-module `buck_phase_fsm`, instantiated twice, contains:
  - threshold arithmetic, counter, state register, gate decode;
  - an `allow_on` input for interleave arbitration;
  - an `ocp` output.
- The top level contains the target split, fault latch, arbitration and `busy`.

## Test plan
All scenarios use DEAD_TIME=4, MIN_ON=8, MIN_OFF=8.
- Reset mid-HI: assert `rst_n`=0 while phase A is in HI. All gates go 0 immediately (asynchronous). After release, the FSM is in OFF.
- Regulation: `enable`=1, `i_set`=200, `hyst`=20, `i_meas_a` ramps 0→120.
  - `gate_lo_a` is on, then after 4 low cycles `gate_hi_a`=1.
  - At `i_meas_a`=110, after ≥8 HI cycles, `gate_hi_a`=0 at the next edge, then 4 dead cycles, then `gate_lo_a`=1.
- Minimum on-time: `i_meas_a` jumps to 150 two cycles after HI entry. Turn-off occurs exactly when the HI counter reaches 8.
- Interleave: both phases satisfy the turn-on condition on the same cycle. A enters DT_HI, and B enters DT_HI no earlier than one cycle later.
- Overcurrent: `i_limit`=300, `i_meas_b`=300 while B is in HI.
  - `fault`=1 and all four gates 0 one edge later.
  - `fault` holds after the current drops.
  - `fault` clears one edge after `enable`=0.
- Zero setpoint: `i_set`=0, `enable`=1, currents 0. `gate_lo_a`=`gate_lo_b`=1 and the high gates stay 0 for 1000 cycles.
- All scenarios: an assertion checks that the hi and lo gates of a leg are never both 1.
